// File: rtl/alu_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// alu_cmd_ctrl
//
// Command front-end for an external 4-bit combinational ALU.
//
// A command (opcode + operands) is accepted over a valid/ready handshake. On
// acceptance the ALU pins (A, B, B_inv, SEL) are registered and then held
// stable for SETTLE_CYCLES cycles. On the last settle cycle the ALU result
// and overflow are sampled and pushed into a small first-word-fall-through
// result FIFO, which is drained over a second valid/ready handshake.
//
// An internal 4-bit accumulator captures every legal result so that the
// ACC_ADD / ACC_SUB opcodes can chain arithmetic without re-sending operand A.
//
// Parameters
//   SETTLE_CYCLES  cycles the ALU pins are held before sampling (1..7)
//   RES_DEPTH      result FIFO depth (2 or 4)
//
// Ports
//   clk, rst_n                rising-edge clock, asynchronous active-low reset
//   cmd_valid/cmd_ready       command handshake
//   cmd_op, cmd_a, cmd_b      opcode and operands (cmd_a unused by ACC_* ops)
//   alu_a, alu_b              registered operands to the ALU
//   alu_binv                  ALU B_inv (subtract)
//   alu_sel                   ALU SEL1:SEL0 (00 sum, 01 AND, 10 OR, 11 XOR)
//   alu_out, alu_ov           ALU result and signed overflow
//   res_valid/res_ready       result handshake (FIFO head)
//   res_data                  result value
//   res_ov                    signed overflow, 0 for logic ops and errors
//   res_zero                  res_data == 0
//   res_err                   illegal opcode marker
// -----------------------------------------------------------------------------
module alu_cmd_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned RES_DEPTH     = 2
) (
  input  logic       clk,
  input  logic       rst_n,

  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,

  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic       alu_binv,
  output logic [1:0] alu_sel,
  input  logic [3:0] alu_out,
  input  logic       alu_ov,

  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_data,
  output logic       res_ov,
  output logic       res_zero,
  output logic       res_err
);

  // ---------------------------------------------------------------------------
  // Types and constants
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    OP_ADD     = 3'd0,
    OP_SUB     = 3'd1,
    OP_AND     = 3'd2,
    OP_OR      = 3'd3,
    OP_XOR     = 3'd4,
    OP_ACC_ADD = 3'd5,
    OP_ACC_SUB = 3'd6,
    OP_ILLEGAL = 3'd7
  } op_e;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRIVE = 1'b1
  } state_e;

  // One FIFO entry: everything the consumer sees for a single result.
  typedef struct packed {
    logic [3:0] data;
    logic       ov;
    logic       zero;
    logic       err;
  } res_t;

  localparam logic [1:0] SEL_SUM = 2'b00;
  localparam logic [1:0] SEL_AND = 2'b01;
  localparam logic [1:0] SEL_OR  = 2'b10;
  localparam logic [1:0] SEL_XOR = 2'b11;

  localparam int unsigned PTR_W = $clog2(RES_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [2:0]       SETTLE_LAST = 3'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT   = CNT_W'(RES_DEPTH);

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  state_e            state;
  state_e            next_state;
  logic [2:0]        settle_cnt;

  op_e               cmd_op_e;
  logic              cmd_accept;
  logic              push;
  logic              pop;

  // Pin values the current command would load; defaults hold the old pins.
  logic [3:0]        pin_a_d;
  logic [3:0]        pin_b_d;
  logic              pin_binv_d;
  logic [1:0]        pin_sel_d;
  logic              ov_en_d;
  logic              err_d;

  // Attributes of the command in flight, captured at acceptance.
  logic              ov_en_q;
  logic              err_q;

  logic [3:0]        acc;

  res_t              fifo_mem [RES_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  res_t              push_entry;
  res_t              head;

  assign cmd_op_e = op_e'(cmd_op);

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: every output of this block is given a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    next_state = state;
    cmd_ready  = 1'b0;
    push       = 1'b0;
    case (state)
      S_IDLE: begin
        // Only one command is ever in flight, so a free FIFO slot now is
        // guaranteed to still be free when its result is pushed.
        cmd_ready = rst_n && (count < DEPTH_CNT);
        if (cmd_valid && cmd_ready) begin
          next_state = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (settle_cnt == SETTLE_LAST) begin
          push       = 1'b1;
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  assign cmd_accept = cmd_valid && cmd_ready;

  // Settle counter: zero whenever idle, so it starts at 0 on the first DRIVE
  // cycle and reaches SETTLE_LAST on the sampling cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
    end else if (state == S_DRIVE) begin
      settle_cnt <= settle_cnt + 3'd1;
    end else begin
      settle_cnt <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Opcode decode to ALU pin values
  // ---------------------------------------------------------------------------
  always_comb begin
    pin_a_d    = alu_a;
    pin_b_d    = alu_b;
    pin_binv_d = alu_binv;
    pin_sel_d  = alu_sel;
    ov_en_d    = 1'b0;
    err_d      = 1'b0;
    case (cmd_op_e)
      OP_ADD, OP_SUB: begin
        pin_a_d    = cmd_a;
        pin_b_d    = cmd_b;
        pin_binv_d = (cmd_op_e == OP_SUB);
        pin_sel_d  = SEL_SUM;
        ov_en_d    = 1'b1;
      end
      OP_ACC_ADD, OP_ACC_SUB: begin
        pin_a_d    = acc;
        pin_b_d    = cmd_b;
        pin_binv_d = (cmd_op_e == OP_ACC_SUB);
        pin_sel_d  = SEL_SUM;
        ov_en_d    = 1'b1;
      end
      OP_AND: begin
        pin_a_d    = cmd_a;
        pin_b_d    = cmd_b;
        pin_binv_d = 1'b0;
        pin_sel_d  = SEL_AND;
      end
      OP_OR: begin
        pin_a_d    = cmd_a;
        pin_b_d    = cmd_b;
        pin_binv_d = 1'b0;
        pin_sel_d  = SEL_OR;
      end
      OP_XOR: begin
        pin_a_d    = cmd_a;
        pin_b_d    = cmd_b;
        pin_binv_d = 1'b0;
        pin_sel_d  = SEL_XOR;
      end
      default: begin
        // Illegal opcode: pins keep their old values, the command still runs
        // through DRIVE so every command has the same latency.
        err_d = 1'b1;
      end
    endcase
  end

  // Pins only move on the acceptance edge, so the ALU sees a clean, stable
  // operand set for the whole settle window and between commands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_binv <= 1'b0;
      alu_sel  <= SEL_SUM;
      ov_en_q  <= 1'b0;
      err_q    <= 1'b0;
    end else if (cmd_accept) begin
      alu_a    <= pin_a_d;
      alu_b    <= pin_b_d;
      alu_binv <= pin_binv_d;
      alu_sel  <= pin_sel_d;
      ov_en_q  <= ov_en_d;
      err_q    <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Result formation and accumulator
  // ---------------------------------------------------------------------------
  always_comb begin
    if (err_q) begin
      push_entry = '{data: 4'h0, ov: 1'b0, zero: 1'b1, err: 1'b1};
    end else begin
      push_entry = '{data: alu_out,
                     ov:   ov_en_q && alu_ov,
                     zero: (alu_out == 4'h0),
                     err:  1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (push && !err_q) begin
      acc <= alu_out;
    end
  end

  // ---------------------------------------------------------------------------
  // Result FIFO (first-word fall-through)
  // ---------------------------------------------------------------------------
  assign pop = res_valid && res_ready;

  // NOTE: the storage array is not reset; occupancy is tracked by the reset
  // pointers/count and the head is masked while empty, so stale contents are
  // never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head      = fifo_mem[rd_ptr];
  assign res_valid = (count != '0);
  assign res_data  = res_valid ? head.data : 4'h0;
  assign res_ov    = res_valid && head.ov;
  assign res_zero  = res_valid && head.zero;
  assign res_err   = res_valid && head.err;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_ctrl
//
// Directed bench for alu_cmd_ctrl. Two instances share one clock:
//   u_dut   SETTLE_CYCLES=1, RES_DEPTH=2 (main function, FIFO back-pressure)
//   u_dut3  SETTLE_CYCLES=3, RES_DEPTH=2 (reset mid-DRIVE, longer latency)
// Each drives a behavioural 4-bit ALU. force_ov lets the model assert its
// overflow pin regardless of the operation, to show logic ops mask it.
// Inputs change 1 time unit after the rising edge; outputs are compared
// 1-2 time units after the rising edge.
// -----------------------------------------------------------------------------
module tb_alu_cmd_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic force_ov = 1'b0;

  // ---- instance 1 (SETTLE_CYCLES = 1) ----
  logic       rst_n, cmd_valid, cmd_ready, res_valid, res_ready;
  logic       res_ov, res_zero, res_err, alu_binv, alu_ov;
  logic [2:0] cmd_op;
  logic [3:0] cmd_a, cmd_b, alu_a, alu_b, alu_out, res_data;
  logic [1:0] alu_sel;

  // ---- instance 2 (SETTLE_CYCLES = 3) ----
  logic       s3_rst_n, s3_cmd_valid, s3_cmd_ready, s3_res_valid, s3_res_ready;
  logic       s3_res_ov, s3_res_zero, s3_res_err, s3_alu_binv, s3_alu_ov;
  logic [2:0] s3_cmd_op;
  logic [3:0] s3_cmd_a, s3_cmd_b, s3_alu_a, s3_alu_b, s3_alu_out, s3_res_data;
  logic [1:0] s3_alu_sel;

  // Packed views for compact comparisons.
  logic [7:0]  res_tuple, s3_res_tuple, exp_res;
  logic [10:0] pins, s3_pins, exp_pins;
  assign res_tuple    = {res_valid, res_data, res_ov, res_zero, res_err};
  assign s3_res_tuple = {s3_res_valid, s3_res_data, s3_res_ov, s3_res_zero, s3_res_err};
  assign pins         = {alu_a, alu_b, alu_binv, alu_sel};
  assign s3_pins      = {s3_alu_a, s3_alu_b, s3_alu_binv, s3_alu_sel};

  // Behavioural ALU: {ov, out}. Overflow is the adder's signed overflow.
  function automatic logic [4:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic binv, input logic [1:0] sel,
                                           input logic fov);
    logic [3:0] bb, s, r;
    logic       ov;
    bb = binv ? ~b : b;
    s  = a + bb + {3'b000, binv};
    ov = (a[3] == bb[3]) && (s[3] != a[3]);
    case (sel)
      2'b00:   r = s;
      2'b01:   r = a & bb;
      2'b10:   r = a | bb;
      default: r = a ^ bb;
    endcase
    return {ov | fov, r};
  endfunction

  assign {alu_ov, alu_out}       = alu_model(alu_a, alu_b, alu_binv, alu_sel, force_ov);
  assign {s3_alu_ov, s3_alu_out} = alu_model(s3_alu_a, s3_alu_b, s3_alu_binv, s3_alu_sel, force_ov);

  alu_cmd_ctrl #(.SETTLE_CYCLES(1), .RES_DEPTH(2)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_binv  (alu_binv),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .alu_ov    (alu_ov),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_ov    (res_ov),
    .res_zero  (res_zero),
    .res_err   (res_err)
  );

  alu_cmd_ctrl #(.SETTLE_CYCLES(3), .RES_DEPTH(2)) u_dut3 (
    .clk       (clk),
    .rst_n     (s3_rst_n),
    .cmd_valid (s3_cmd_valid),
    .cmd_ready (s3_cmd_ready),
    .cmd_op    (s3_cmd_op),
    .cmd_a     (s3_cmd_a),
    .cmd_b     (s3_cmd_b),
    .alu_a     (s3_alu_a),
    .alu_b     (s3_alu_b),
    .alu_binv  (s3_alu_binv),
    .alu_sel   (s3_alu_sel),
    .alu_out   (s3_alu_out),
    .alu_ov    (s3_alu_ov),
    .res_valid (s3_res_valid),
    .res_ready (s3_res_ready),
    .res_data  (s3_res_data),
    .res_ov    (s3_res_ov),
    .res_zero  (s3_res_zero),
    .res_err   (s3_res_err)
  );

  // ---------------------------------------------------------------------------
  // Stimulus helpers (no comparisons inside)
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a command for one edge; operands are scrambled afterwards so a
  // design that samples them late would pick up wrong values.
  task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    step();
    cmd_valid = 1'b0; cmd_a = ~a; cmd_b = ~b;
  endtask

  task automatic send3(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    s3_cmd_valid = 1'b1; s3_cmd_op = op; s3_cmd_a = a; s3_cmd_b = b;
    step();
    s3_cmd_valid = 1'b0; s3_cmd_a = ~a; s3_cmd_b = ~b;
  endtask

  task automatic pop();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic pop3();
    s3_res_ready = 1'b1;
    step();
    s3_res_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0; s3_rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_op = 3'd0; cmd_a = 4'h0; cmd_b = 4'h0; res_ready = 1'b0;
    s3_cmd_valid = 1'b0; s3_cmd_op = 3'd0; s3_cmd_a = 4'h0; s3_cmd_b = 4'h0; s3_res_ready = 1'b0;
    step();
    step();
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready_low got=%b exp=0", cmd_ready); end
    vectors++; if (s3_cmd_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready_low_s3 got=%b exp=0", s3_cmd_ready); end
    rst_n = 1'b1; s3_rst_n = 1'b1;
    step();
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
    vectors++; if (res_tuple !== 8'h00) begin miscompares++; $display("FAIL reset_res got=%b exp=%b", res_tuple, 8'h00); end
    vectors++; if (pins !== 11'h000) begin miscompares++; $display("FAIL reset_pins got=%h exp=%h", pins, 11'h000); end
    vectors++; if (s3_cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready_s3 got=%b exp=1", s3_cmd_ready); end
  endtask

  task automatic test_add();
    send(3'd0, 4'h5, 4'h3);
    exp_pins = {4'h5, 4'h3, 1'b0, 2'b00};
    vectors++; if (pins !== exp_pins) begin miscompares++; $display("FAIL add_pins got=%h exp=%h", pins, exp_pins); end
    vectors++; if ({cmd_ready, res_valid} !== 2'b00) begin miscompares++; $display("FAIL add_drive_flags got=%b exp=00", {cmd_ready, res_valid}); end
    step();
    exp_res = {1'b1, 4'h8, 1'b1, 1'b0, 1'b0};
    vectors++; if (res_tuple !== exp_res) begin miscompares++; $display("FAIL add_res got=%b exp=%b", res_tuple, exp_res); end
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL add_ready_after got=%b exp=1", cmd_ready); end
    pop();
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL add_popped got=%b exp=0", res_valid); end
  endtask

  task automatic test_sub_acc();
    send(3'd1, 4'h3, 4'h5);
    exp_pins = {4'h3, 4'h5, 1'b1, 2'b00};
    vectors++; if (pins !== exp_pins) begin miscompares++; $display("FAIL sub_pins got=%h exp=%h", pins, exp_pins); end
    step();
    exp_res = {1'b1, 4'hE, 1'b0, 1'b0, 1'b0};
    vectors++; if (res_tuple !== exp_res) begin miscompares++; $display("FAIL sub_res got=%b exp=%b", res_tuple, exp_res); end
    pop();
    // ACC_SUB: operand A comes from the accumulator (0xE), cmd_a is ignored.
    send(3'd6, 4'h9, 4'hE);
    exp_pins = {4'hE, 4'hE, 1'b1, 2'b00};
    vectors++; if (pins !== exp_pins) begin miscompares++; $display("FAIL accsub_pins got=%h exp=%h", pins, exp_pins); end
    step();
    exp_res = {1'b1, 4'h0, 1'b0, 1'b1, 1'b0};
    vectors++; if (res_tuple !== exp_res) begin miscompares++; $display("FAIL accsub_res got=%b exp=%b", res_tuple, exp_res); end
    pop();
  endtask

  task automatic test_logic();
    logic [2:0] ops  [3] = '{3'd2, 3'd3, 3'd4};
    logic [1:0] sels [3] = '{2'b01, 2'b10, 2'b11};
    logic [3:0] exps [3] = '{4'h8, 4'hE, 4'h6};
    force_ov = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(ops[i], 4'hC, 4'hA);
      exp_pins = {4'hC, 4'hA, 1'b0, sels[i]};
      vectors++; if (pins !== exp_pins) begin miscompares++; $display("FAIL logic_pins[%0d] got=%h exp=%h", i, pins, exp_pins); end
      step();
      exp_res = {1'b1, exps[i], 1'b0, 1'b0, 1'b0};
      vectors++; if (res_tuple !== exp_res) begin miscompares++; $display("FAIL logic_res[%0d] got=%b exp=%b", i, res_tuple, exp_res); end
      pop();
    end
    force_ov = 1'b0;
  endtask

  task automatic test_illegal();
    send(3'd0, 4'h1, 4'h2);
    step();
    exp_res = {1'b1, 4'h3, 1'b0, 1'b0, 1'b0};
    vectors++; if (res_tuple !== exp_res) begin miscompares++; $display("FAIL ill_pre_res got=%b exp=%b", res_tuple, exp_res); end
    pop();
    send(3'd7, 4'hF, 4'hF);
    exp_pins = {4'h1, 4'h2, 1'b0, 2'b00};
    vectors++; if (pins !== exp_pins) begin miscompares++; $display("FAIL ill_pins got=%h exp=%h", pins, exp_pins); end
    vectors++; if ({cmd_ready, res_valid} !== 2'b00) begin miscompares++; $display("FAIL ill_drive_flags got=%b exp=00", {cmd_ready, res_valid}); end
    step();
    exp_res = {1'b1, 4'h0, 1'b0, 1'b1, 1'b1};
    vectors++; if (res_tuple !== exp_res) begin miscompares++; $display("FAIL ill_res got=%b exp=%b", res_tuple, exp_res); end
    pop();
    // Accumulator must still hold 3 from the ADD before the illegal op.
    send(3'd5, 4'h9, 4'h1);
    exp_pins = {4'h3, 4'h1, 1'b0, 2'b00};
    vectors++; if (pins !== exp_pins) begin miscompares++; $display("FAIL ill_acc_pins got=%h exp=%h", pins, exp_pins); end
    step();
    exp_res = {1'b1, 4'h4, 1'b0, 1'b0, 1'b0};
    vectors++; if (res_tuple !== exp_res) begin miscompares++; $display("FAIL ill_acc_res got=%b exp=%b", res_tuple, exp_res); end
    pop();
  endtask

  task automatic test_back_to_back();
    res_ready = 1'b0;
    send(3'd0, 4'h1, 4'h1);
    step();
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_one got=%b exp=1", cmd_ready); end
    send(3'd0, 4'h2, 4'h2);
    step();
    exp_res = {1'b1, 4'h2, 1'b0, 1'b0, 1'b0};
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_full got=%b exp=0", cmd_ready); end
    vectors++; if (res_tuple !== exp_res) begin miscompares++; $display("FAIL b2b_head_full got=%b exp=%b", res_tuple, exp_res); end
    // Third command waits while the FIFO is full.
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 4'h3; cmd_b = 4'h3;
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_wait_ready[%0d] got=%b exp=0", i, cmd_ready); end
      vectors++; if (alu_a !== 4'h2) begin miscompares++; $display("FAIL b2b_wait_pins[%0d] got=%h exp=2", i, alu_a); end
      vectors++; if (res_tuple !== exp_res) begin miscompares++; $display("FAIL b2b_head_stable[%0d] got=%b exp=%b", i, res_tuple, exp_res); end
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    exp_res = {1'b1, 4'h4, 1'b0, 1'b0, 1'b0};
    vectors++; if (res_tuple !== exp_res) begin miscompares++; $display("FAIL b2b_second got=%b exp=%b", res_tuple, exp_res); end
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_after_pop got=%b exp=1", cmd_ready); end
    step();
    cmd_valid = 1'b0;
    exp_pins = {4'h3, 4'h3, 1'b0, 2'b00};
    vectors++; if (pins !== exp_pins) begin miscompares++; $display("FAIL b2b_third_pins got=%h exp=%h", pins, exp_pins); end
    vectors++; if (res_tuple !== exp_res) begin miscompares++; $display("FAIL b2b_head_during_drive got=%b exp=%b", res_tuple, exp_res); end
    // Push of the third result and pop of the second on the same edge.
    res_ready = 1'b1;
    step();
    exp_res = {1'b1, 4'h6, 1'b0, 1'b0, 1'b0};
    vectors++; if (res_tuple !== exp_res) begin miscompares++; $display("FAIL b2b_third got=%b exp=%b", res_tuple, exp_res); end
    step();
    res_ready = 1'b0;
    vectors++; if (res_tuple !== 8'h00) begin miscompares++; $display("FAIL b2b_empty got=%b exp=%b", res_tuple, 8'h00); end
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_end got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_reset_mid_drive();
    send3(3'd0, 4'h5, 4'h3);
    exp_pins = {4'h5, 4'h3, 1'b0, 2'b00};
    vectors++; if (s3_pins !== exp_pins) begin miscompares++; $display("FAIL rmd_pins got=%h exp=%h", s3_pins, exp_pins); end
    step();
    s3_rst_n = 1'b0;
    #1;
    vectors++; if (s3_pins !== 11'h000) begin miscompares++; $display("FAIL rmd_pins_clear got=%h exp=%h", s3_pins, 11'h000); end
    vectors++; if ({s3_cmd_ready, s3_res_tuple} !== 9'h000) begin miscompares++; $display("FAIL rmd_outputs_clear got=%b exp=%b", {s3_cmd_ready, s3_res_tuple}, 9'h000); end
    step();
    step();
    s3_rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      vectors++; if (s3_res_valid !== 1'b0) begin miscompares++; $display("FAIL rmd_no_result[%0d] got=%b exp=0", i, s3_res_valid); end
    end
    vectors++; if (s3_cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rmd_ready got=%b exp=1", s3_cmd_ready); end
  endtask

  task automatic test_settle3();
    send3(3'd0, 4'h7, 4'h1);
    for (int i = 0; i < 3; i++) begin
      vectors++; if ({s3_cmd_ready, s3_res_valid} !== 2'b00) begin miscompares++; $display("FAIL s3_drive_flags[%0d] got=%b exp=00", i, {s3_cmd_ready, s3_res_valid}); end
      step();
    end
    exp_res = {1'b1, 4'h8, 1'b1, 1'b0, 1'b0};
    vectors++; if (s3_res_tuple !== exp_res) begin miscompares++; $display("FAIL s3_res got=%b exp=%b", s3_res_tuple, exp_res); end
    pop3();
    vectors++; if (s3_res_valid !== 1'b0) begin miscompares++; $display("FAIL s3_popped got=%b exp=0", s3_res_valid); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_acc();
    test_logic();
    test_illegal();
    test_back_to_back();
    test_reset_mid_drive();
    test_settle3();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
